// File: rtl/sram_host_arbiter.sv
// Shares the external 8-bit SRAM between the machine core (default owner, combinational pass-through)
// and a host DMA port that gets fixed 3-cycle transactions inside machine-free slots.
module sram_host_arbiter #(
  parameter int AW      = 21,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [18:0]   m_addr,
  input  logic          m_we_n,
  input  logic [7:0]    m_dout,
  input  logic          m_doe,
  output logic [7:0]    m_din,
  input  logic          host_slot,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [7:0]    h_wdata,
  output logic          h_ack,
  output logic [7:0]    h_rdata,
  output logic          h_busy,
  output logic          h_starved,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we_n,
  output logic [7:0]    sram_dout,
  output logic          sram_doe,
  input  logic [7:0]    sram_din
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    H_SETUP  = 2'd1,
    H_STROBE = 2'd2,
    H_HOLD   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg;
  logic            we_reg;
  logic [7:0]      wdata_reg;
  logic [7:0]      rdata_reg;
  logic            ack_reg;
  logic            starved_reg;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            grant;

  // A host transaction may only start when the machine has promised a free window.
  assign grant = (state_reg == IDLE) && h_req && host_slot;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (grant) state_next = H_SETUP;
      H_SETUP:  state_next = H_STROBE;
      H_STROBE: state_next = H_HOLD;
      H_HOLD:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    if (grant || !h_req)
      cnt_next = '0;
    else if (state_reg == IDLE && cnt_reg != CNT_MAX)
      cnt_next = cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      ack_reg     <= 1'b0;
      starved_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= (state_reg == H_HOLD);
      if (grant) begin
        addr_reg  <= h_addr;
        we_reg    <= h_we;
        wdata_reg <= h_wdata;
      end
      // Read data is sampled at the end of the strobe cycle, then held until the next read.
      if (state_reg == H_STROBE && !we_reg)
        rdata_reg <= sram_din;
      if (grant)
        starved_reg <= 1'b0;
      else if (cnt_next == CNT_MAX)
        starved_reg <= 1'b1;
    end
  end

  always_comb begin
    sram_addr = {{(AW-19){1'b0}}, m_addr};
    sram_we_n = m_we_n;
    sram_dout = m_dout;
    sram_doe  = m_doe;
    if (state_reg != IDLE) begin
      sram_addr = addr_reg;
      sram_we_n = !(state_reg == H_STROBE && we_reg);
      sram_dout = wdata_reg;
      sram_doe  = we_reg;
    end
    // Reset must release the bus instantly, even if the machine is mid-write.
    if (!reset_n) begin
      sram_we_n = 1'b1;
      sram_doe  = 1'b0;
    end
  end

  assign m_din     = sram_din;
  assign h_ack     = ack_reg;
  assign h_rdata   = rdata_reg;
  assign h_busy    = (state_reg != IDLE);
  assign h_starved = starved_reg;

endmodule
